// File: rtl/dense_argmax_select.sv
// Final classification stage: latches one dense-layer output vector, scans it one
// element per clock, and reports the argmax index/value plus a threshold mask.
module dense_argmax_select #(
  parameter  int QN         = 6,
  parameter  int QM         = 11,
  parameter  int FINAL_SIZE = 16,
  parameter  int THRESH     = 1024,
  localparam int BW         = QN + QM + 1,
  localparam int IDX_W      = (FINAL_SIZE > 1) ? $clog2(FINAL_SIZE) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [FINAL_SIZE*BW-1:0] inputVec,
  input  logic                     dataReady,
  output logic                     in_ready,
  output logic [IDX_W-1:0]         outIndex,
  output logic [BW-1:0]            outValue,
  output logic [FINAL_SIZE-1:0]    outMask,
  output logic                     dataReady_out,
  input  logic                     out_ready,
  output logic [1:0]               state_dbg
);

  // Handshakes: a vector transfers on the posedge where dataReady && in_ready;
  // a result transfers on the posedge where dataReady_out && out_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic signed [BW-1:0] THRESH_S = BW'(THRESH);
  localparam logic [IDX_W:0]       CNT_END  = (IDX_W + 1)'(FINAL_SIZE);

  state_t state, state_nxt;

  logic signed [BW-1:0]   vec_r [FINAL_SIZE];
  logic [IDX_W:0]         cnt;
  logic [IDX_W-1:0]       cnt_idx;
  logic signed [BW-1:0]   max_val;
  logic [IDX_W-1:0]       max_idx;
  logic [FINAL_SIZE-1:0]  mask_r;
  logic signed [BW-1:0]   elem0;
  logic signed [BW-1:0]   cur_elem;
  logic [FINAL_SIZE-1:0]  first_mask;
  logic                   capture;

  assign in_ready  = (state == IDLE) && reset;
  assign state_dbg = state;
  assign capture   = dataReady && in_ready;
  assign cnt_idx   = cnt[IDX_W-1:0];
  assign elem0     = inputVec[BW-1:0];
  assign cur_elem  = vec_r[cnt_idx];

  always_comb begin
    first_mask    = '0;
    first_mask[0] = (elem0 > THRESH_S);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture) state_nxt = (FINAL_SIZE == 1) ? HOLD : SCAN;
      SCAN: if (cnt == CNT_END) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt runs to FINAL_SIZE so the last element is folded in before outputs load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FINAL_SIZE; i++) vec_r[i] <= '0;
      cnt           <= '0;
      max_val       <= '0;
      max_idx       <= '0;
      mask_r        <= '0;
      outIndex      <= '0;
      outValue      <= '0;
      outMask       <= '0;
      dataReady_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < FINAL_SIZE; i++) vec_r[i] <= inputVec[i*BW +: BW];
            cnt     <= (IDX_W + 1)'(1);
            max_val <= elem0;
            max_idx <= '0;
            mask_r  <= first_mask;
            if (FINAL_SIZE == 1) begin
              outIndex      <= '0;
              outValue      <= elem0;
              outMask       <= first_mask;
              dataReady_out <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (cnt == CNT_END) begin
            outIndex      <= max_idx;
            outValue      <= max_val;
            outMask       <= mask_r;
            dataReady_out <= 1'b1;
          end else begin
            // Strict compare keeps the lowest index on ties.
            if (cur_elem > max_val) begin
              max_val <= cur_elem;
              max_idx <= cnt_idx;
            end
            mask_r[cnt_idx] <= (cur_elem > THRESH_S);
            cnt             <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) dataReady_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_argmax_select.sv
// Directed bench for dense_argmax_select: argmax, ties, signed values, threshold
// mask, latency, backpressure, reset abort and back-to-back streaming.
module tb_dense_argmax_select;

  localparam int FS = 16;
  localparam int BW = 18;
  localparam int IW = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [FS*BW-1:0] inputVec;
  logic            dataReady;
  logic            in_ready;
  logic [IW-1:0]   outIndex;
  logic [BW-1:0]   outValue;
  logic [FS-1:0]   outMask;
  logic            dataReady_out;
  logic            out_ready;
  logic [1:0]      state_dbg;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  dense_argmax_select dut (
    .clock(clock), .reset(reset), .inputVec(inputVec), .dataReady(dataReady),
    .in_ready(in_ready), .outIndex(outIndex), .outValue(outValue), .outMask(outMask),
    .dataReady_out(dataReady_out), .out_ready(out_ready), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [FS*BW-1:0] fill(input logic [BW-1:0] val);
    logic [FS*BW-1:0] v;
    for (int i = 0; i < FS; i++) v[i*BW +: BW] = val;
    return v;
  endfunction

  function automatic logic [FS*BW-1:0] put(input logic [FS*BW-1:0] v_in, input int idx,
                                           input logic [BW-1:0] val);
    logic [FS*BW-1:0] v;
    v = v_in;
    v[idx*BW +: BW] = val;
    return v;
  endfunction

  // Called at a negedge with in_ready high; returns clocks from capture edge to result.
  task automatic run_vec(input logic [FS*BW-1:0] v, output int lat);
    inputVec  = v;
    dataReady = 1'b1;
    @(negedge clock);
    dataReady = 1'b0;
    lat = 0;
    while (!dataReady_out && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [FS*BW-1:0] v;
    int lat, n, c1, c2;
    bit stable, quiet;

    reset = 1'b0; dataReady = 1'b0; out_ready = 1'b0; inputVec = '0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", dataReady_out, 0);
    check("rst_index", outIndex, 0);
    check("rst_value", outValue, 0);
    check("rst_mask", outMask, 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_in_ready", in_ready, 1);

    // Single max, with latency measurement
    v = '0;
    for (int i = 0; i < FS; i++) v = put(v, i, BW'(100 * i));
    v = put(v, 9, 18'd4000);
    inputVec = v; dataReady = 1'b1;
    @(negedge clock);
    dataReady = 1'b0;
    check("scan_in_ready", in_ready, 0);
    check("scan_state", state_dbg, 1);
    lat = 0;
    while (!dataReady_out && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("max_latency", lat, 16);
    check("max_index", outIndex, 9);
    check("max_value", outValue, 4000);
    check("max_mask", outMask, 32'hFA00);

    // Backpressure: new vector offered while result is held
    inputVec = fill(18'd5000); dataReady = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!(outIndex == 9 && outValue == 4000 && outMask == 16'hFA00 &&
            dataReady_out && !in_ready && state_dbg == 2'd2)) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_valid_drop", dataReady_out, 0);
    check("bp_in_ready", in_ready, 1);
    check("bp_no_capture_idx", outIndex, 9);
    dataReady = 1'b0; out_ready = 1'b0;
    @(negedge clock);

    // Tie resolves to lowest index
    v = '0; v = put(v, 3, 18'd2047); v = put(v, 12, 18'd2047);
    run_vec(v, lat);
    check("tie_latency", lat, 16);
    check("tie_index", outIndex, 3);
    check("tie_value", outValue, 2047);
    check("tie_mask", outMask, 32'h1008);
    consume();

    // Signed compare, all negative
    v = fill(18'h3FF9C); v = put(v, 5, 18'h3FFFF);
    run_vec(v, lat);
    check("neg_index", outIndex, 5);
    check("neg_value", outValue, 32'h3FFFF);
    check("neg_mask", outMask, 0);
    consume();

    // Max at the last element; threshold boundary (1024 is not above THRESH)
    v = fill(18'd1024); v = put(v, 15, 18'd1025);
    run_vec(v, lat);
    check("last_index", outIndex, 15);
    check("last_value", outValue, 1025);
    check("last_mask", outMask, 32'h8000);
    consume();

    // All equal above threshold: index 0 wins, full mask
    run_vec(fill(18'd1025), lat);
    check("eq_index", outIndex, 0);
    check("eq_mask", outMask, 32'hFFFF);
    consume();

    // Reset mid-scan aborts; reset also wins over dataReady
    inputVec = fill(18'd7); dataReady = 1'b1;
    @(negedge clock);
    dataReady = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0; dataReady = 1'b1;
    #1;
    check("abort_index", outIndex, 0);
    check("abort_value", outValue, 0);
    check("abort_mask", outMask, 0);
    check("abort_valid", dataReady_out, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clock);
    reset = 1'b1; dataReady = 1'b0;
    @(negedge clock);
    check("post_rst_state", state_dbg, 0);
    check("post_rst_in_ready", in_ready, 1);
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (dataReady_out) quiet = 1'b0;
    end
    check("no_partial_result", quiet, 1);

    // Streaming: dataReady and out_ready both held high
    v = fill(18'd10); v = put(v, 7, 18'd300);
    inputVec = v; dataReady = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    v = fill(18'd2000); v = put(v, 14, 18'd30000);
    inputVec = v;
    n = 0;
    while (!dataReady_out && n < 40) begin
      @(negedge clock);
      n++;
    end
    c1 = cyc;
    check("strm_a_latency", n, 16);
    check("strm_a_index", outIndex, 7);
    check("strm_a_value", outValue, 300);
    n = 0;
    while (dataReady_out && n < 5) begin
      @(negedge clock);
      n++;
    end
    while (!dataReady_out && n < 60) begin
      @(negedge clock);
      n++;
    end
    c2 = cyc;
    check("strm_spacing", c2 - c1, 18);
    check("strm_b_index", outIndex, 14);
    check("strm_b_value", outValue, 30000);
    check("strm_b_mask", outMask, 32'hFFFF);
    dataReady = 1'b0;
    @(negedge clock);
    out_ready = 1'b0;
    @(negedge clock);
    check("end_idle", state_dbg, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
